// File: rtl/uart_sample_plotter.sv
// Pixel-colour stage behind the VGA timing generator: keeps received UART bytes in a 1024-entry ring
// and draws them as a scrolling green trace over a grey grid, exactly six pixel clocks after the counters.
module uart_sample_plotter #(
   parameter int         H_ACTIVE  = 1024,
   parameter int         V_ACTIVE  = 768,
   parameter int         ADDR_W    = 10,
   parameter int         GRID_STEP = 64,
   parameter logic [7:0] GRID_LVL  = 8'h40
) (
   input  logic          pixel_clk,
   input  logic          reset_n,
   input  logic [7:0]    rx_data,
   input  logic          rx_valid,
   output logic          rx_ready,
   input  logic          freeze,
   input  logic [11:0]   h_count,
   input  logic [9:0]    v_count,
   input  logic          blank_n,
   input  logic          eof,
   output logic [10:0]   fill_cnt,
   output logic [7:0]    RED,
   output logic [7:0]    GREEN,
   output logic [7:0]    BLUE
);
   localparam int                GRID_SH   = $clog2(GRID_STEP);
   localparam logic [ADDR_W:0]   FILL_FULL = (ADDR_W + 1)'(H_ACTIVE);
   localparam logic [ADDR_W:0]   FILL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W - 1){1'b0}}, 1'b1};
   localparam logic [11:0]       H_LIM     = 12'(H_ACTIVE);
   localparam logic [9:0]        V_LIM     = 10'(V_ACTIVE);
   localparam logic [9:0]        V_LAST    = 10'(V_ACTIVE - 1);
   localparam logic [23:0]       RGB_TRACE = 24'h00FF00;
   localparam logic [23:0]       RGB_GRID  = {GRID_LVL, GRID_LVL, GRID_LVL};
   localparam logic [23:0]       RGB_BLACK = 24'h000000;

   // A sample v occupies three lines starting 3v lines above the bottom of the screen.
   function automatic logic trace_hit(input logic [7:0] v, input logic [9:0] y);
      logic [9:0] v3;
      v3 = {1'b0, v, 1'b0} + {2'b00, v};
      return (y >= v3) && (y <= v3 + 10'd2);
   endfunction

   logic              rx_ready_q;
   logic              accept_s;
   logic [ADDR_W-1:0] wr_ptr_q,     wr_ptr_d;
   logic [ADDR_W:0]   fill_q,       fill_d;
   logic [ADDR_W-1:0] base_ptr_q,   base_ptr_d;
   logic [ADDR_W:0]   frame_fill_q, frame_fill_d;
   logic [7:0]        sample_mem [0:H_ACTIVE-1];

   logic [ADDR_W-1:0] addr_s;
   logic              has_s, act_s, grid_s;
   logic [ADDR_W-1:0] s1_addr_q;
   logic [9:0]        s1_v_q, s2_v_q, s3_v_q;
   logic              s1_act_q, s2_act_q, s3_act_q, s4_act_q;
   logic              s1_has_q, s2_has_q, s3_has_q;
   logic              s1_grid_q, s2_grid_q, s3_grid_q, s4_grid_q;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [7:0]        mem_rd_q;
   logic [9:0]        y_s;
   logic              hit_s, s4_hit_q;
   logic [23:0]       colour_s, s5_rgb_q, s6_rgb_q;

   // Write pointer, saturating fill count and the frame snapshot taken on eof (after this cycle's write).
   always_comb begin
      accept_s     = rx_valid & rx_ready_q;
      wr_ptr_d     = wr_ptr_q;
      fill_d       = fill_q;
      base_ptr_d   = base_ptr_q;
      frame_fill_d = frame_fill_q;
      if (accept_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (fill_q != FILL_FULL) begin
            fill_d = fill_q + FILL_ONE;
         end else begin
            fill_d = fill_q;
         end
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (eof) begin
         base_ptr_d   = wr_ptr_d;
         frame_fill_d = fill_d;
      end else begin
         base_ptr_d   = base_ptr_q;
         frame_fill_d = frame_fill_q;
      end
   end

   // Write-side state registers; rx_ready follows freeze with one cycle of lag.
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_ready_q   <= 1'b0;
         wr_ptr_q     <= '0;
         fill_q       <= '0;
         base_ptr_q   <= '0;
         frame_fill_q <= '0;
      end else begin
         rx_ready_q   <= ~freeze;
         wr_ptr_q     <= wr_ptr_d;
         fill_q       <= fill_d;
         base_ptr_q   <= base_ptr_d;
         frame_fill_q <= frame_fill_d;
      end
   end

   // Sample RAM: simple dual port, registered read returns old data on a same-address collision.
   always_ff @(posedge pixel_clk) begin
      if (accept_s) begin
         sample_mem[wr_ptr_q] <= rx_data;
      end
      mem_rd_q <= sample_mem[rd_addr_q];
   end

   // Column to buffer address: a full buffer scrolls from the oldest sample, a partial one starts at 0.
   always_comb begin
      act_s  = (h_count < H_LIM) && (v_count < V_LIM) && blank_n;
      grid_s = (h_count[GRID_SH-1:0] == '0) || (v_count[GRID_SH-1:0] == '0);
      if (frame_fill_q == FILL_FULL) begin
         addr_s = base_ptr_q + h_count[ADDR_W-1:0];
         has_s  = 1'b1;
      end else begin
         addr_s = h_count[ADDR_W-1:0];
         has_s  = (h_count < 12'(frame_fill_q));
      end
   end

   // Trace compare against the sample read for this column.
   always_comb begin
      y_s   = V_LAST - s3_v_q;
      hit_s = s3_act_q & s3_has_q & trace_hit(mem_rd_q, y_s);
   end

   // Colour priority: blanked/outside, then trace, then grid, then black.
   always_comb begin
      colour_s = RGB_BLACK;
      if (!s4_act_q) begin
         colour_s = RGB_BLACK;
      end else if (s4_hit_q) begin
         colour_s = RGB_TRACE;
      end else if (s4_grid_q) begin
         colour_s = RGB_GRID;
      end else begin
         colour_s = RGB_BLACK;
      end
   end

   // Six-stage display pipeline: capture, read address, read data, compare, colour select, RGB.
   always_ff @(posedge pixel_clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_addr_q <= '0;
         s1_v_q    <= '0;
         s1_act_q  <= 1'b0;
         s1_has_q  <= 1'b0;
         s1_grid_q <= 1'b0;
         rd_addr_q <= '0;
         s2_v_q    <= '0;
         s2_act_q  <= 1'b0;
         s2_has_q  <= 1'b0;
         s2_grid_q <= 1'b0;
         s3_v_q    <= '0;
         s3_act_q  <= 1'b0;
         s3_has_q  <= 1'b0;
         s3_grid_q <= 1'b0;
         s4_hit_q  <= 1'b0;
         s4_act_q  <= 1'b0;
         s4_grid_q <= 1'b0;
         s5_rgb_q  <= '0;
         s6_rgb_q  <= '0;
      end else begin
         s1_addr_q <= addr_s;
         s1_v_q    <= v_count;
         s1_act_q  <= act_s;
         s1_has_q  <= has_s;
         s1_grid_q <= grid_s;
         rd_addr_q <= s1_addr_q;
         s2_v_q    <= s1_v_q;
         s2_act_q  <= s1_act_q;
         s2_has_q  <= s1_has_q;
         s2_grid_q <= s1_grid_q;
         s3_v_q    <= s2_v_q;
         s3_act_q  <= s2_act_q;
         s3_has_q  <= s2_has_q;
         s3_grid_q <= s2_grid_q;
         s4_hit_q  <= hit_s;
         s4_act_q  <= s3_act_q;
         s4_grid_q <= s3_grid_q;
         s5_rgb_q  <= colour_s;
         s6_rgb_q  <= s5_rgb_q;
      end
   end

   assign rx_ready = rx_ready_q;
   assign fill_cnt = fill_q;
   assign RED      = s6_rgb_q[23:16];
   assign GREEN    = s6_rgb_q[15:8];
   assign BLUE     = s6_rgb_q[7:0];

endmodule
